fetch_ctrl: RTL

//  Instruction fetch stage directly upstream of decode. Owns the PC and issues word

---
 rtl/fetch_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch stage feeding decode.
// Owns the PC and issues word requests over a valid/ready channel. In-order
// responses land in a small {pc,insn} queue whose head is shown to decode.
// A redirect flushes the queue and marks in-flight fetches as stale so their
// responses are discarded before any target word is queued.
// Optional feature: define FETCH_BYPASS_EN to let a non-stale response reach
// valid_o/pc_o/insn_o in the same cycle when the queue is empty.
module fetch_ctrl #(
    parameter int unsigned       AWIDTH   = 32,
    parameter int unsigned       DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
    parameter int unsigned       QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid_o,
    output logic [AWIDTH-1:0] req_addr_o,
    input  logic              req_ready_i,
    input  logic              rsp_valid_i,
    input  logic [DWIDTH-1:0] rsp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
);

    localparam int unsigned       PW  = $clog2(QDEPTH);
    localparam int unsigned       CW  = $clog2(QDEPTH + 1);
    localparam logic [DWIDTH-1:0] NOP = DWIDTH'(32'h0000_0013);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] rsp_pc;
    logic [AWIDTH-1:0] target;
    logic [AWIDTH-1:0] q_pc   [QDEPTH];
    logic [DWIDTH-1:0] q_insn [QDEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     inflight_nxt;
    logic [CW-1:0]     stale;
    logic [CW:0]       occupancy;
    logic              req_fire;
    logic              rsp_live;
    logic              push;
    logic              pop;
    logic              q_valid;
    logic              byp;

    assign target       = redirect_pc_i & ~AWIDTH'(3);
    assign occupancy    = {1'b0, count} + {1'b0, inflight};
    assign req_valid_o  = (state == RUN) && !redirect_i && (occupancy < (CW + 1)'(QDEPTH));
    assign req_addr_o   = pc;
    assign req_fire     = req_valid_o && req_ready_i;
    assign inflight_nxt = inflight + CW'(req_fire) - CW'(rsp_valid_i);
    assign rsp_live     = rsp_valid_i && (stale == '0) && !redirect_i;
    assign q_valid      = (count != '0);
    assign pop          = q_valid && ready_i && !redirect_i;

`ifdef FETCH_BYPASS_EN
    // With count==1 and a pop, the response is simply pushed behind the head,
    // so the combinational path is only needed for an empty queue.
    assign byp  = rsp_live && (state == RUN) && !q_valid;
    assign push = rsp_live && !(byp && ready_i);
`else
    assign byp  = 1'b0;
    assign push = rsp_live;
`endif

    // Head of queue (or bypassed response) toward decode; NOP/0 when idle.
    always_comb begin
        valid_o = q_valid || byp;
        pc_o    = '0;
        insn_o  = NOP;
        if (q_valid) begin
            pc_o   = q_pc[rd_ptr];
            insn_o = q_insn[rd_ptr];
        end else if (byp) begin
            pc_o   = rsp_pc;
            insn_o = rsp_data_i;
        end
    end

    // Queue storage; contents are only meaningful where count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= rsp_pc;
            q_insn[wr_ptr] <= rsp_data_i;
        end
    end

    // FSM, PC/response-PC tracking, credits, stale count and queue pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= BASEADDR;
            rsp_pc   <= BASEADDR;
            count    <= '0;
            inflight <= '0;
            stale    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= inflight_nxt;
            case (state)
                IDLE:    state <= RUN;
                RUN:     state <= RUN;
                default: state <= IDLE;
            endcase
            if (redirect_i) begin
                // Everything still outstanding after this cycle becomes stale.
                pc     <= target;
                rsp_pc <= target;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                stale  <= inflight_nxt;
            end else begin
                if (req_fire) begin
                    pc <= pc + AWIDTH'(4);
                end
                if (rsp_valid_i) begin
                    if (stale != '0) begin
                        stale <= stale - CW'(1);
                    end else begin
                        rsp_pc <= rsp_pc + AWIDTH'(4);
                    end
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Credit rule must keep a push from landing on a full queue.
    overflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (count == CW'(QDEPTH))));
`endif

endmodule
